// File: rtl/x_mem_bus_pkg.sv
// Shared types and address map for the x_mem_bus memory/peripheral target.
package x_mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        RAM,
        GPIO,
        TIMER,
        NONE
    } region_t;

    localparam logic [31:0] GPIO_ADDR  = 32'h8000_0000;
    localparam logic [31:0] TIMER_ADDR = 32'h8000_0004;

    // Byte-lane bits are ignored everywhere, so only addr[31:2] takes part in the decode.
    function automatic region_t decode_region(input logic [31:0] addr, input int unsigned aw);
        if (addr[31:2] == GPIO_ADDR[31:2]) begin
            return GPIO;
        end
        if (addr[31:2] == TIMER_ADDR[31:2]) begin
            return TIMER;
        end
        if (!addr[31] && ((addr[30:0] >> (aw + 2)) == 31'd0)) begin
            return RAM;
        end
        return NONE;
    endfunction

endpackage

// File: rtl/x_sp_ram.sv
// Single-port word RAM with registered read data (read-before-write); contents are never reset.
module x_sp_ram #(
    parameter int AW = 8
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_addr] <= i_wdata;
        end
        o_rdata <= mem[i_addr];
    end

endmodule

// File: rtl/x_mem_bus.sv
// Memory/peripheral target for the rv32i core: three-cycle request FSM serving RAM, GPIO and a timer.
module x_mem_bus
    import x_mem_bus_pkg::*;
#(
    parameter int RAM_AW = 8
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_valid,
    input  logic              i_rnw,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_data,
    output logic              o_accept,
    output logic [31:0]       o_data,
    output logic              o_err,
    input  logic              i_load_en,
    input  logic [RAM_AW-1:0] i_load_addr,
    input  logic [31:0]       i_load_data,
    output logic [31:0]       o_gpio
);

    state_t      state_reg;
    logic [31:0] req_addr_reg;
    logic [31:0] req_data_reg;
    logic        req_rnw_reg;
    logic        accept_reg;
    logic        err_reg;
    logic        rd_from_ram_reg;
    logic [31:0] rd_data_reg;
    logic [31:0] gpio_reg;
    logic [31:0] timer_reg;
    logic [31:0] timer_next;
    region_t     region;

    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    always_comb begin
        region = decode_region(req_addr_reg, RAM_AW);
    end

    // A timer read returns the count as it stands at the end of ACCESS, so a
    // write-then-read pair sees three increments between the two ACCESS cycles.
    always_comb begin
        timer_next = timer_reg + 32'd1;
        if (state_reg == ACCESS && !req_rnw_reg && region == TIMER) begin
            timer_next = req_data_reg;
        end
    end

    // The load port owns the RAM in IDLE; the captured request owns it otherwise.
    always_comb begin
        if (state_reg == IDLE) begin
            ram_we    = i_load_en;
            ram_addr  = i_load_addr;
            ram_wdata = i_load_data;
        end else begin
            ram_we    = (state_reg == ACCESS) && !req_rnw_reg && (region == RAM);
            ram_addr  = req_addr_reg[RAM_AW+1:2];
            ram_wdata = req_data_reg;
        end
    end

    x_sp_ram #(
        .AW(RAM_AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_addr  (ram_addr),
        .i_wdata (ram_wdata),
        .o_rdata (ram_rdata)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_reg       <= IDLE;
            req_addr_reg    <= '0;
            req_data_reg    <= '0;
            req_rnw_reg     <= 1'b0;
            accept_reg      <= 1'b0;
            err_reg         <= 1'b0;
            rd_from_ram_reg <= 1'b0;
            rd_data_reg     <= '0;
            gpio_reg        <= '0;
            timer_reg       <= '0;
        end else begin
            timer_reg       <= timer_next;
            accept_reg      <= 1'b0;
            err_reg         <= 1'b0;
            rd_from_ram_reg <= 1'b0;
            rd_data_reg     <= '0;
            case (state_reg)
                IDLE: begin
                    if (!i_load_en && i_valid) begin
                        req_addr_reg <= i_addr;
                        req_data_reg <= i_data;
                        req_rnw_reg  <= i_rnw;
                        state_reg    <= ACCESS;
                    end
                end
                ACCESS: begin
                    accept_reg      <= 1'b1;
                    err_reg         <= (region == NONE);
                    rd_from_ram_reg <= req_rnw_reg && (region == RAM);
                    if (req_rnw_reg) begin
                        if (region == GPIO) begin
                            rd_data_reg <= gpio_reg;
                        end else if (region == TIMER) begin
                            rd_data_reg <= timer_next;
                        end
                    end else if (region == GPIO) begin
                        gpio_reg <= req_data_reg;
                    end
                    state_reg <= RESP;
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // RAM read data lands in the RAM's own output register during RESP.
    assign o_accept = accept_reg;
    assign o_err    = err_reg;
    assign o_data   = accept_reg ? (rd_from_ram_reg ? ram_rdata : rd_data_reg) : '0;
    assign o_gpio   = gpio_reg;

endmodule

// File: tb/tb_x_mem_bus.sv
// Directed self-checking bench for x_mem_bus: one task per feature, hand-computed expectations.
module tb_x_mem_bus;

    localparam int RAM_AW = 8;

    logic              i_clk;
    logic              i_nrst;
    logic              i_valid;
    logic              i_rnw;
    logic [31:0]       i_addr;
    logic [31:0]       i_data;
    logic              o_accept;
    logic [31:0]       o_data;
    logic              o_err;
    logic              i_load_en;
    logic [RAM_AW-1:0] i_load_addr;
    logic [31:0]       i_load_data;
    logic [31:0]       o_gpio;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    x_mem_bus #(
        .RAM_AW(RAM_AW)
    ) dut (
        .i_clk       (i_clk),
        .i_nrst      (i_nrst),
        .i_valid     (i_valid),
        .i_rnw       (i_rnw),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .o_accept    (o_accept),
        .o_data      (o_data),
        .o_err       (o_err),
        .i_load_en   (i_load_en),
        .i_load_addr (i_load_addr),
        .i_load_data (i_load_data),
        .o_gpio      (o_gpio)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Drives a request at the current negedge and waits (bounded) for o_accept.
    // i_valid is left high so the caller can chain a back-to-back request.
    task automatic bus_req(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int lat);
        bit done;
        i_valid = 1'b1;
        i_rnw   = rnw;
        i_addr  = addr;
        i_data  = wdata;
        lat     = -1;
        rdata   = '0;
        err     = 1'b0;
        done    = 0;
        for (int c = 1; c <= 8 && !done; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_accept) begin
                lat   = c;
                rdata = o_data;
                err   = o_err;
                done  = 1;
            end
        end
        $display("txn rnw=%0b addr=%08h wdata=%08h -> rdata=%08h err=%0b lat=%0d @cyc %0d",
                 rnw, addr, wdata, rdata, err, lat, cyc);
    endtask

    task automatic bus_idle();
        i_valid = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic ram_load(input logic [RAM_AW-1:0] idx, input logic [31:0] val);
        i_load_en   = 1'b1;
        i_load_addr = idx;
        i_load_data = val;
        @(negedge i_clk);
        i_load_en   = 1'b0;
        $display("txn load idx=%0d data=%08h @cyc %0d", idx, val, cyc);
    endtask

    task automatic test_reset();
        checks++; if (o_accept !== 1'b0) begin errors++; $display("FAIL reset_accept got %0b exp 0", o_accept); end
        checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL reset_data got %08h exp 00000000", o_data); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", o_err); end
        checks++; if (o_gpio !== 32'h0) begin errors++; $display("FAIL reset_gpio got %08h exp 00000000", o_gpio); end
    endtask

    task automatic test_load_read();
        logic [31:0] rd; logic er; int lat;
        ram_load(8'd3, 32'h1234_5678);
        bus_req(1'b1, 32'h0000_000C, 32'h0, rd, er, lat);
        bus_idle();
        checks++; if (lat !== 2) begin errors++; $display("FAIL load_read_lat got %0d exp 2", lat); end
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL load_read_data got %08h exp 12345678", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_read_err got %0b exp 0", er); end
        // Highest RAM word is still mapped.
        ram_load(8'd255, 32'hDEAD_BEEF);
        bus_req(1'b1, 32'h0000_03FC, 32'h0, rd, er, lat);
        bus_idle();
        checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin errors++; $display("FAIL top_word got %08h/%0b exp deadbeef/0", rd, er); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat; int t_wr; int t_rd;
        bus_req(1'b0, 32'h0000_0010, 32'hCAFE_F00D, rd, er, lat);
        t_wr = cyc;
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL write_resp got %08h/%0b exp 00000000/0", rd, er); end
        bus_req(1'b1, 32'h0000_0010, 32'h0, rd, er, lat);
        t_rd = cyc;
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL write_read_data got %08h exp cafef00d", rd); end
        checks++; if (t_rd - t_wr !== 3) begin errors++; $display("FAIL b2b_spacing got %0d exp 3", t_rd - t_wr); end
        bus_idle();
        checks++; if (o_accept !== 1'b0) begin errors++; $display("FAIL accept_one_cycle got %0b exp 0", o_accept); end
    endtask

    task automatic test_gpio();
        logic [31:0] rd; logic er; int lat;
        i_valid = 1'b1; i_rnw = 1'b0; i_addr = 32'h8000_0000; i_data = 32'hA5A5_0001;
        @(posedge i_clk); @(negedge i_clk);
        checks++; if (o_gpio !== 32'h0) begin errors++; $display("FAIL gpio_during_access got %08h exp 00000000", o_gpio); end
        @(posedge i_clk); @(negedge i_clk);
        checks++; if (o_gpio !== 32'hA5A5_0001) begin errors++; $display("FAIL gpio_after_access got %08h exp a5a50001", o_gpio); end
        checks++; if (o_accept !== 1'b1 || o_err !== 1'b0) begin errors++; $display("FAIL gpio_write_accept got %0b/%0b exp 1/0", o_accept, o_err); end
        $display("txn rnw=0 addr=80000000 wdata=a5a50001 -> gpio=%08h @cyc %0d", o_gpio, cyc);
        bus_req(1'b1, 32'h8000_0000, 32'h0, rd, er, lat);
        bus_idle();
        checks++; if (rd !== 32'hA5A5_0001) begin errors++; $display("FAIL gpio_read got %08h exp a5a50001", rd); end
    endtask

    task automatic test_timer_wrap();
        logic [31:0] rd; logic er; int lat;
        bus_req(1'b0, 32'h8000_0004, 32'hFFFF_FFFE, rd, er, lat);
        bus_req(1'b1, 32'h8000_0004, 32'h0, rd, er, lat);
        bus_idle();
        checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL timer_wrap got %08h exp 00000001", rd); end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd; logic er; int lat;
        bus_req(1'b1, 32'h4000_0000, 32'h0, rd, er, lat);
        bus_idle();
        checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL unmapped_read got %08h/%0b exp 00000000/1", rd, er); end
        bus_req(1'b0, 32'h8000_0008, 32'h1111_2222, rd, er, lat);
        bus_idle();
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL unmapped_write_err got %0b exp 1", er); end
        checks++; if (o_gpio !== 32'hA5A5_0001) begin errors++; $display("FAIL unmapped_write_gpio got %08h exp a5a50001", o_gpio); end
        bus_req(1'b1, 32'h0000_0400, 32'h0, rd, er, lat);
        bus_idle();
        checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL ram_edge_unmapped got %08h/%0b exp 00000000/1", rd, er); end
    endtask

    task automatic test_priority();
        int lat; bit done; logic [31:0] rd;
        i_load_en = 1'b1; i_load_addr = 8'd7; i_load_data = 32'h0BAD_BEEF;
        i_valid = 1'b1; i_rnw = 1'b1; i_addr = 32'h0000_001C; i_data = 32'h0;
        lat = -1; rd = '0; done = 0;
        for (int c = 1; c <= 8 && !done; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            i_load_en = 1'b0;
            if (o_accept) begin
                lat = c; rd = o_data; done = 1;
            end
        end
        $display("txn load+read idx=7 addr=0000001c -> rdata=%08h lat=%0d @cyc %0d", rd, lat, cyc);
        bus_idle();
        checks++; if (lat !== 3) begin errors++; $display("FAIL priority_lat got %0d exp 3", lat); end
        checks++; if (rd !== 32'h0BAD_BEEF) begin errors++; $display("FAIL priority_data got %08h exp 0badbeef", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; int acc_seen;
        ram_load(8'd5, 32'h1111_1111);
        i_valid = 1'b1; i_rnw = 1'b0; i_addr = 32'h0000_0014; i_data = 32'h2222_2222;
        @(posedge i_clk);
        #2 i_nrst = 1'b0;
        #1;
        checks++; if (o_accept !== 1'b0 || o_data !== 32'h0 || o_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outputs got %0b/%08h/%0b exp 0/00000000/0", o_accept, o_data, o_err); end
        checks++; if (o_gpio !== 32'h0) begin errors++; $display("FAIL rst_mid_gpio got %08h exp 00000000", o_gpio); end
        @(negedge i_clk);
        i_valid = 1'b0;
        acc_seen = 0;
        for (int c = 0; c < 2; c++) begin
            @(posedge i_clk); @(negedge i_clk);
            if (o_accept) acc_seen++;
        end
        checks++; if (acc_seen !== 0) begin errors++; $display("FAIL rst_mid_no_accept got %0d exp 0", acc_seen); end
        $display("txn reset during ram write addr=00000014 @cyc %0d", cyc);
        i_nrst = 1'b1;
        bus_req(1'b1, 32'h8000_0004, 32'h0, rd, er, lat);
        bus_idle();
        checks++; if (lat !== 2) begin errors++; $display("FAIL rst_release_lat got %0d exp 2", lat); end
        checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL rst_timer got %08h exp 00000002", rd); end
        bus_req(1'b1, 32'h0000_0014, 32'h0, rd, er, lat);
        bus_idle();
        checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL rst_write_lost got %08h exp 11111111", rd); end
    endtask

    initial begin
        i_nrst = 1'b0; i_valid = 1'b0; i_rnw = 1'b0; i_addr = '0; i_data = '0;
        i_load_en = 1'b0; i_load_addr = '0; i_load_data = '0;
        repeat (3) @(negedge i_clk);
        test_reset();
        i_nrst = 1'b1;
        @(negedge i_clk);
        test_load_read();
        test_back_to_back();
        test_gpio();
        test_timer_wrap();
        test_unmapped();
        test_priority();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
